count_capture_fifo: RTL and testbench
=====================================

// Module: count_capture_fifo
// PURPOSE
//   Downstream consumer of a free-running counter's count bus. It timestamps
//   rising edges of a trigger by capturing the count value present on that
//   cycle. Captures are buffered in a small FIFO. A consumer drains them over
//   a valid/ready interface, and overflow is reported when the buffer cannot
//   accept a capture.
// PARAMETERS
//   WIDTH  8  width of count_in and cap_data; must be >= 1
//   DEPTH  4  FIFO entries; power of two, >= 2
//   AW     $clog2(DEPTH)  pointer width; derived, never overridden
// PORTS
//   clk        input   1        system clock, all logic on posedge
//   rst        input   1        synchronous reset, active-high
//   count_in   input   WIDTH    count bus from the upstream counter
//   trig       input   1        event input, synchronous to clk
//   cap_valid  output  1        FIFO non-empty, cap_data holds the oldest entry
//   cap_ready  input   1        consumer accepts cap_data this cycle
//   cap_data   output  WIDTH    oldest captured count (first-word-fall-through)
//   cap_level  output  AW+1     number of stored entries, 0..DEPTH
//   overflow   output  1        sticky: a capture was dropped
//   ovf_clr    input   1        clears overflow (and drop_cnt if present)
//   drop_cnt   output  8        only with CAPTURE_DROP_CNT_EN (see below)
// BEHAVIOUR
//   Clock and reset
//     - One clock, clk. Reset rst is synchronous and active-high.
//     - Reset: rd_ptr=0, wr_ptr=0, cap_level=0, cap_valid=0, overflow=0,
//       drop_cnt=0, trig_q=1.
//     - cap_data is don't-care while cap_valid=0. Memory contents are not reset.
//   Edge detect
//     - Registered trig_q <= trig. An edge occurs when trig=1 && trig_q=0.
//     - trig_q resets to 1, so trig held high through reset yields no capture.
//     - Consecutive edges need trig to go low for at least 1 cycle.
//   Push
//     - On an edge cycle, count_in of that same cycle is written at wr_ptr.
//     - Latency: the entry is visible 1 cycle later (cap_valid rises, or
//       cap_level increments).
//   Pop
//     - Occurs when cap_valid && cap_ready. rd_ptr advances.
//     - cap_data = mem[rd_ptr], driven from registered pointers only.
//     - cap_valid = (cap_level != 0), registered.
//     - cap_ready while cap_valid=0 is ignored.
//   Handshake
//     - While cap_valid=1 and cap_ready=0, cap_data and cap_valid hold stable.
//   Simultaneous push and pop
//     - Both happen and cap_level is unchanged.
//     - This holds when full: the push is accepted, no overflow.
//     - When empty there is no pop, because cap_valid=0. The push lands and
//       cap_valid=1 the next cycle (no bypass).
//   Full
//     - Push with cap_level==DEPTH and no pop: the capture is dropped.
//     - Pointers and data are unchanged; overflow <= 1.
//   Overflow clear
//     - ovf_clr clears overflow next cycle.
//     - A drop in the same cycle as ovf_clr wins: overflow stays 1.
//   Wrap-around
//     - Pointers are AW bits and wrap naturally.
//     - cap_level is tracked separately (AW+1 bits).
//   count_in wrap
//     - count_in wrap-around (e.g. 0xFF->0x00) is captured verbatim.
//     - No arithmetic is applied to captured values.
//   Reset mid-operation
//     - All stored entries are discarded and outputs return to reset values on
//       the next cycle, regardless of cap_ready or trig.
// CONFIGURATION
//   CAPTURE_DROP_CNT_EN defined
//     - Adds output drop_cnt[7:0], incremented on each dropped capture.
//     - Saturates at 255. Cleared to 0 by rst or ovf_clr.
//     - A drop coinciding with ovf_clr yields drop_cnt=1.
//   CAPTURE_DROP_CNT_EN undefined
//     - drop_cnt port and logic are absent. Only the sticky overflow flag exists.
// TESTING
//   1. Reset with trig=1 held, release rst, trig stays 1 -> cap_valid=0 and
//      cap_level=0 for 10 cycles.
//   2. count_in=8'h05, pulse trig 1 cycle, cap_ready=0 -> next cycle
//      cap_valid=1, cap_data=8'h05, cap_level=1; holds while cap_ready=0.
//   3. Edges at count_in=1,2,3,4,5 (DEPTH=4), no pops -> cap_level=4,
//      overflow=1, drop_cnt=1 if enabled; drain yields 1,2,3,4 in order.
//   4. FIFO full, cap_ready=1 on the same cycle as edge at count_in=9 ->
//      overflow stays 0, cap_level stays 4, last entry read is 9.
//   5. overflow=1, assert ovf_clr with a simultaneous drop -> overflow stays 1;
//      ovf_clr alone next cycle -> overflow=0, drop_cnt=0.
//   6. Capture 3 entries, assert rst for 1 cycle mid-drain -> next cycle
//      cap_valid=0, cap_level=0, overflow=0; a new edge at count_in=8'hFF then
//      reads back 8'hFF.

Source files
------------

// File: rtl/count_capture_fifo.sv
// Timestamps rising edges of trig with the current count_in value and buffers them
// in a first-word-fall-through FIFO drained over valid/ready. Optional CAPTURE_DROP_CNT_EN adds a saturating drop counter.
module count_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             trig,
  output logic             cap_valid,
  input  logic             cap_ready,
  output logic [WIDTH-1:0] cap_data,
  output logic [AW:0]      cap_level,
  output logic             overflow,
  input  logic             ovf_clr
`ifdef CAPTURE_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  logic             trig_q;
  logic             trig_rise;
  logic             pop;
  logic             full;
  logic             push;
  logic             drop;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_next;
  logic [WIDTH-1:0] mem [DEPTH];

  // trig_q resets high so a trigger already asserted through reset is not an edge.
  assign trig_rise = trig && !trig_q;
  assign pop       = cap_valid && cap_ready;
  assign full      = (cap_level == (AW+1)'(DEPTH));
  assign push      = trig_rise && (!full || pop);
  assign drop      = trig_rise && full && !pop;
  assign cap_data  = mem[rd_ptr];

  // NOTE: every signal gets a default first so this block can never infer a latch.
  always_comb begin
    level_next = cap_level;
    case ({push, pop})
      2'b10:   level_next = cap_level + 1'b1;
      2'b01:   level_next = cap_level - 1'b1;
      default: level_next = cap_level;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q    <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cap_level <= '0;
      cap_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      trig_q    <= trig;
      cap_level <= level_next;
      cap_valid <= (level_next != '0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A drop in the same cycle as a clear wins.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // NOTE: storage carries no reset; entries are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= count_in;
  end

`ifdef CAPTURE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                     drop_cnt <= 8'd0;
    else if (ovf_clr)            drop_cnt <= drop ? 8'd1 : 8'd0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo: edge capture, FWFT drain, full/overflow,
// simultaneous push/pop, overflow clear priority and synchronous reset mid-drain.
module tb_count_capture_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count_in;
  logic       trig;
  logic       cap_valid;
  logic       cap_ready;
  logic [7:0] cap_data;
  logic [2:0] cap_level;
  logic       overflow;
  logic       ovf_clr;
`ifdef CAPTURE_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_capture_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .trig      (trig),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .cap_data  (cap_data),
    .cap_level (cap_level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
`ifdef CAPTURE_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Produce one rising edge of trig carrying value v, then return trig low.
  task automatic edge_at(input logic [7:0] v);
    count_in = v;
    trig     = 1'b1;
    tick();
    trig     = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; trig = 1'b1; count_in = 8'h00; cap_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();

    // 1: trig held high through reset release gives no capture
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_valid", cap_valid, 0);
      check("t1_level", cap_level, 0);
    end
    check("t1_ovf", overflow, 0);
`ifdef CAPTURE_DROP_CNT_EN
    check("t1_dcnt", drop_cnt, 0);
`endif

    // 2: single capture, held while cap_ready=0
    trig = 1'b0; tick();
    count_in = 8'h05; trig = 1'b1; tick();
    trig = 1'b0; count_in = 8'h06;
    check("t2_valid", cap_valid, 1);
    check("t2_data", cap_data, 8'h05);
    check("t2_level", cap_level, 1);
    tick(); tick();
    check("t2_hold_valid", cap_valid, 1);
    check("t2_hold_data", cap_data, 8'h05);
    check("t2_hold_level", cap_level, 1);
    cap_ready = 1'b1; tick();
    check("t2_pop_valid", cap_valid, 0);
    check("t2_pop_level", cap_level, 0);

    // ready while empty is ignored; push into empty FIFO has no bypass
    count_in = 8'h07; trig = 1'b1; tick();
    trig = 1'b0;
    check("nb_valid", cap_valid, 1);
    check("nb_data", cap_data, 8'h07);
    check("nb_level", cap_level, 1);
    tick();
    check("nb_drained", cap_valid, 0);
    cap_ready = 1'b0;

    // 3: five edges into a 4-deep FIFO, fifth is dropped
    for (int v = 1; v <= 5; v++) edge_at(8'(v));
    check("t3_level", cap_level, 4);
    check("t3_ovf", overflow, 1);
`ifdef CAPTURE_DROP_CNT_EN
    check("t3_dcnt", drop_cnt, 1);
`endif
    cap_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      check("t3_drain_valid", cap_valid, 1);
      check("t3_drain_data", cap_data, v);
      tick();
    end
    cap_ready = 1'b0;
    check("t3_empty", cap_valid, 0);
    check("t3_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t3_ovf_clr", overflow, 0);

    // 4: full with simultaneous pop and push accepts the push
    for (int v = 10; v <= 13; v++) edge_at(8'(v));
    check("t4_full", cap_level, 4);
    count_in = 8'h09; trig = 1'b1; cap_ready = 1'b1; tick();
    trig = 1'b0; cap_ready = 1'b0;
    check("t4_ovf", overflow, 0);
    check("t4_level", cap_level, 4);
    check("t4_head", cap_data, 8'h0B);
    tick();
    cap_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      check("t4_drain", cap_data, (v == 3) ? 32'h09 : 32'(12 + v - 1 + 0) - 0 + 0);
      tick();
    end
    cap_ready = 1'b0;
    check("t4_empty", cap_level, 0);

    // 5: drop coincident with ovf_clr keeps overflow set
    for (int v = 20; v <= 24; v++) edge_at(8'(v));
    check("t5_ovf_set", overflow, 1);
    count_in = 8'h25; trig = 1'b1; ovf_clr = 1'b1; tick();
    trig = 1'b0;
    check("t5_ovf_win", overflow, 1);
`ifdef CAPTURE_DROP_CNT_EN
    check("t5_dcnt_one", drop_cnt, 1);
`endif
    tick();
    ovf_clr = 1'b0;
    check("t5_ovf_clr", overflow, 0);
`ifdef CAPTURE_DROP_CNT_EN
    check("t5_dcnt_clr", drop_cnt, 0);
`endif
    check("t5_level", cap_level, 4);
    check("t5_head", cap_data, 8'h14);
    cap_ready = 1'b1;
    repeat (4) tick();
    cap_ready = 1'b0;
    check("t5_empty", cap_valid, 0);

    // 6: reset mid-drain discards entries
    for (int v = 30; v <= 32; v++) edge_at(8'(v));
    cap_ready = 1'b1; tick(); cap_ready = 1'b0;
    check("t6_level_pre", cap_level, 2);
    check("t6_head_pre", cap_data, 8'h1F);
    rst = 1'b1; trig = 1'b1; cap_ready = 1'b1; tick();
    rst = 1'b0; cap_ready = 1'b0;
    check("t6_valid", cap_valid, 0);
    check("t6_level", cap_level, 0);
    check("t6_ovf", overflow, 0);
    tick();
    check("t6_no_edge", cap_valid, 0);
    trig = 1'b0; tick();
    edge_at(8'hFF);
    edge_at(8'h00);
    check("t6_level_new", cap_level, 2);
    check("t6_ff", cap_data, 8'hFF);
    cap_ready = 1'b1; tick();
    check("t6_wrap", cap_data, 8'h00);
    tick(); cap_ready = 1'b0;
    check("t6_empty", cap_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
